// File: rtl/dac_channel_scheduler_if.sv
// Signal bundle between the requesters / DacSpi engine and the channel scheduler.
interface dac_channel_scheduler_if;
    logic [3:0]  req;          // per-channel write strobe
    logic [47:0] wr_data;      // {ch3,ch2,ch1,ch0}, 12 bits each
    logic [11:0] data;         // value presented to DacSpi
    logic [3:0]  address;      // channel address presented to DacSpi
    logic [3:0]  command;      // command nibble presented to DacSpi
    logic        dactrig;      // one-cycle start pulse
    logic        dacdone;      // DacSpi completion pulse
    logic        busy;         // transfer in flight
    logic [3:0]  pending;      // channels waiting to be sent
    logic        timeout_err;  // sticky watchdog flag

    // Environment side: requesters plus the DacSpi completion strobe.
    modport master (
        output req, wr_data, dacdone,
        input  data, address, command, dactrig, busy, pending, timeout_err
    );

    // Scheduler side.
    modport slave (
        input  req, wr_data, dacdone,
        output data, address, command, dactrig, busy, pending, timeout_err
    );
endinterface

// File: rtl/dac_channel_scheduler.sv
// Four-channel DAC write scheduler: shadow registers with pending flags,
// round-robin grant, one-cycle trigger towards DacSpi and a completion watchdog.
module dac_channel_scheduler #(
    parameter logic [3:0] CMD_WRITE      = 4'b0011,
    parameter int         TIMEOUT_CYCLES = 4096
) (
    input  logic                   CLK50MHZ,
    input  logic                   RST,
    dac_channel_scheduler_if.slave dac
);
    localparam int               CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_TRIG = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]       r_state;
    logic [11:0]      r_shadow [4];
    logic [3:0]       r_pending;
    logic [1:0]       r_ptr;
    logic [1:0]       r_ch;
    logic [CNT_W-1:0] r_cnt;
    logic [11:0]      r_data;
    logic [3:0]       r_address;
    logic [3:0]       r_command;
    logic             r_dactrig;
    logic             r_busy;
    logic             r_timeout_err;

    logic             w_found;
    logic [1:0]       w_sel;
    logic             w_grant;
    logic             w_timeout;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [3:0]       w_pending_next;

    // Round-robin pick: first pending channel at or after the pointer (the
    // loop runs from the farthest offset so the nearest one is kept last).
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            if (r_pending[r_ptr + 2'(k)]) begin
                w_found = 1'b1;
                w_sel   = r_ptr + 2'(k);
            end
        end
    end

    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_grant   = (r_state == S_IDLE) && w_found;
    assign w_timeout = (r_state == S_WAIT) && !dac.dacdone && (w_cnt_inc == CNT_LIMIT);

    // Pending flags: grant clears, timeout re-arms, a fresh request always wins.
    always_comb begin
        w_pending_next = r_pending;
        if (w_grant) begin
            w_pending_next[w_sel] = 1'b0;
        end
        if (w_timeout) begin
            w_pending_next[r_ch] = 1'b1;
        end
        w_pending_next = w_pending_next | dac.req;
    end

    // Shadow capture runs in every state; the last write before a grant wins.
    always_ff @(posedge CLK50MHZ or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 4; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (dac.req[i]) begin
                    r_shadow[i] <= dac.wr_data[12*i +: 12];
                end
            end
        end
    end

    // Grant / trigger / wait sequencing with the registered DacSpi outputs.
    always_ff @(posedge CLK50MHZ or posedge RST) begin
        if (RST) begin
            r_state       <= S_IDLE;
            r_pending     <= '0;
            r_ptr         <= '0;
            r_ch          <= '0;
            r_cnt         <= '0;
            r_data        <= '0;
            r_address     <= '0;
            r_command     <= '0;
            r_dactrig     <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_pending <= w_pending_next;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        // Shadow is read before this edge's capture, so a
                        // coinciding request is sent in a later round.
                        r_data    <= r_shadow[w_sel];
                        r_address <= {2'b00, w_sel};
                        r_command <= CMD_WRITE;
                        r_ch      <= w_sel;
                        r_dactrig <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= S_TRIG;
                    end
                end
                S_TRIG: begin
                    r_dactrig <= 1'b0;
                    r_cnt     <= '0;
                    r_state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (dac.dacdone) begin
                        r_ptr   <= r_ch + 2'd1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_timeout) begin
                        r_timeout_err <= 1'b1;
                        r_ptr         <= r_ch + 2'd1;
                        r_busy        <= 1'b0;
                        r_state       <= S_IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_dactrig <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign dac.data        = r_data;
    assign dac.address     = r_address;
    assign dac.command     = r_command;
    assign dac.dactrig     = r_dactrig;
    assign dac.busy        = r_busy;
    assign dac.pending     = r_pending;
    assign dac.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_dac_channel_scheduler.sv
// Bench for dac_channel_scheduler: directed scenarios plus randomized traffic,
// all outputs compared every cycle against a transaction-level reference model.
`timescale 1ns/1ps
module tb_dac_channel_scheduler;
    localparam int         TB_TIMEOUT = 16;
    localparam logic [3:0] TB_CMD     = 4'b0011;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    dac_channel_scheduler_if u_if ();

    dac_channel_scheduler #(
        .CMD_WRITE      (TB_CMD),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .CLK50MHZ (clk),
        .RST      (rst),
        .dac      (u_if)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // m_ch < 0 : no transfer in flight.
    // m_age    : edges since the grant (0 = trigger cycle, >=1 = waiting cycles).
    logic [11:0] m_shadow [4];
    logic [3:0]  m_pend;
    int          m_ptr;
    int          m_ch;
    int          m_age;
    logic [11:0] m_data;
    logic [3:0]  m_addr;
    logic        m_cmd;
    logic        m_err;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_shadow[i] = '0;
        m_pend = '0;
        m_ptr  = 0;
        m_ch   = -1;
        m_age  = 0;
        m_data = '0;
        m_addr = '0;
        m_cmd  = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] req, input logic [47:0] wd, input logic done);
        int c;
        if (m_ch < 0) begin
            for (int k = 0; k < 4; k++) begin
                c = (m_ptr + k) % 4;
                if (m_ch < 0 && m_pend[c]) begin
                    m_ch    = c;
                    m_age   = 0;
                    m_data  = m_shadow[c];
                    m_addr  = 4'(c);
                    m_cmd   = 1'b1;
                    m_pend[c] = 1'b0;
                end
            end
        end else if (m_age == 0) begin
            m_age = 1;
        end else if (done) begin
            m_ptr = (m_ch + 1) % 4;
            m_ch  = -1;
        end else if (m_age == TB_TIMEOUT) begin
            m_err        = 1'b1;
            m_pend[m_ch] = 1'b1;
            m_ptr        = (m_ch + 1) % 4;
            m_ch         = -1;
        end else begin
            m_age++;
        end
        for (int i = 0; i < 4; i++) begin
            if (req[i]) begin
                m_shadow[i] = wd[12*i +: 12];
                m_pend[i]   = 1'b1;
            end
        end
    endtask

    function automatic logic [31:0] exp_vec();
        logic trig;
        logic bsy;
        trig = (m_ch >= 0) && (m_age == 0);
        bsy  = (m_ch >= 0);
        return {5'b0, m_data, m_addr, (m_cmd ? TB_CMD : 4'h0), trig, bsy, m_pend, m_err};
    endfunction

    function automatic logic [31:0] dut_vec();
        return {5'b0, u_if.data, u_if.address, u_if.command, u_if.dactrig,
                u_if.busy, u_if.pending, u_if.timeout_err};
    endfunction

    // ---------------- DacSpi responder ----------------
    logic spi_en;
    logic noise_en;
    int   spi_lat;
    int   spi_cnt;

    task automatic spi_step();
        if (rst) begin
            u_if.dacdone = 1'b0;
            spi_cnt      = 0;
        end else begin
            u_if.dacdone = 1'b0;
            if (spi_cnt > 0) begin
                spi_cnt--;
                if (spi_cnt == 0) u_if.dacdone = 1'b1;
            end
            if (u_if.dactrig && spi_en) spi_cnt = spi_lat;
            if (noise_en && $urandom_range(0, 15) == 0) u_if.dacdone = 1'b1;
        end
    endtask

    // ---------------- cycle engine ----------------
    logic [15:0] g_log [$];   // {address, data} of every observed trigger

    task automatic cycle();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step(u_if.req, u_if.wr_data, u_if.dacdone);
        @(negedge clk);
        if (u_if.dactrig) g_log.push_back({u_if.address, u_if.data});
        check_val("cycle_outputs", dut_vec(), exp_vec());
        spi_step();
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic put_ch(input int ch, input logic [11:0] v);
        u_if.req[ch]              = 1'b1;
        u_if.wr_data[12*ch +: 12] = v;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        u_if.req     = '0;
        u_if.dacdone = 1'b0;
        spi_cnt      = 0;
        model_reset();
        cycle();
        cycle();
        rst = 1'b0;
        g_log.delete();
    endtask

    task automatic check_log(input string tag, input int idx, input logic [3:0] ch, input logic [11:0] v);
        if (idx < g_log.size()) check_val(tag, 32'(g_log[idx]), 32'({ch, v}));
        else                    check_val(tag, 32'hFFFF_FFFF, 32'({ch, v}));
    endtask

    initial begin
        int n;
        u_if.req     = '0;
        u_if.wr_data = '0;
        u_if.dacdone = 1'b0;
        spi_en   = 1'b1;
        noise_en = 1'b0;
        spi_lat  = 12;
        spi_cnt  = 0;
        model_reset();

        do_reset();
        check_val("reset_outputs", dut_vec(), 32'h0);

        // Single write on channel 2
        put_ch(2, 12'hABC);
        cycle();
        u_if.req = '0;
        check_val("sw_pending", 32'(u_if.pending), 32'h4);
        check_val("sw_no_early_trig", 32'(u_if.dactrig), 32'h0);
        cycle();
        check_val("sw_trig", 32'(u_if.dactrig), 32'h1);
        check_val("sw_addr", 32'(u_if.address), 32'h2);
        check_val("sw_data", 32'(u_if.data), 32'hABC);
        check_val("sw_cmd", 32'(u_if.command), 32'h3);
        check_val("sw_pending_cleared", 32'(u_if.pending), 32'h0);
        cycle();
        check_val("sw_trig_one_cycle", 32'(u_if.dactrig), 32'h0);
        n = 0;
        while (u_if.busy && n < 100) begin
            cycle();
            n++;
        end
        check_val("sw_busy_fall_cycles", 32'(n), 32'(spi_lat));
        check_val("sw_idle_pending", 32'(u_if.pending), 32'h0);

        // Round robin: all four channels requested in one cycle
        do_reset();
        put_ch(0, 12'h001); put_ch(1, 12'h002); put_ch(2, 12'h003); put_ch(3, 12'h004);
        cycle();
        u_if.req = '0;
        run_cycles(70);
        check_val("rr_trig_count", 32'(g_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) check_log("rr_grant", i, 4'(i), 12'(i + 1));

        // Pointer: after serving ch2, ch3 precedes ch1
        do_reset();
        put_ch(2, 12'h222);
        cycle();
        u_if.req = '0;
        run_cycles(3);
        put_ch(1, 12'h111); put_ch(3, 12'h333);
        cycle();
        u_if.req = '0;
        run_cycles(60);
        check_val("ptr_trig_count", 32'(g_log.size()), 32'd3);
        check_log("ptr_first", 0, 4'd2, 12'h222);
        check_log("ptr_second", 1, 4'd3, 12'h333);
        check_log("ptr_third", 2, 4'd1, 12'h111);

        // Overwrite while the channel is in flight: only the last value follows
        do_reset();
        put_ch(0, 12'h0AA);
        cycle();
        u_if.req = '0;
        cycle();
        put_ch(0, 12'h111);
        cycle();
        put_ch(0, 12'h222);
        cycle();
        u_if.req = '0;
        run_cycles(50);
        check_val("ovw_trig_count", 32'(g_log.size()), 32'd2);
        check_log("ovw_first", 0, 4'd0, 12'h0AA);
        check_log("ovw_second", 1, 4'd0, 12'h222);

        // Request coinciding with the grant edge: old value first, then new
        do_reset();
        put_ch(0, 12'h333);
        cycle();
        put_ch(0, 12'h444);
        cycle();
        u_if.req = '0;
        check_val("coin_data_old", 32'(u_if.data), 32'h333);
        check_val("coin_pending_kept", 32'(u_if.pending), 32'h1);
        run_cycles(50);
        check_val("coin_trig_count", 32'(g_log.size()), 32'd2);
        check_log("coin_second", 1, 4'd0, 12'h444);

        // Watchdog: DacSpi never answers
        do_reset();
        spi_en = 1'b0;
        put_ch(1, 12'h5A5);
        cycle();
        u_if.req = '0;
        cycle();
        check_val("to_trig", 32'(u_if.dactrig), 32'h1);
        n = 0;
        while (!u_if.timeout_err && n < 100) begin
            cycle();
            n++;
        end
        check_val("to_cycles", 32'(n), 32'(TB_TIMEOUT + 1));
        check_val("to_pending_rearmed", 32'(u_if.pending), 32'h2);
        check_val("to_busy_low", 32'(u_if.busy), 32'h0);
        cycle();
        check_val("to_retry_trig", 32'(u_if.dactrig), 32'h1);
        check_val("to_retry_addr", 32'(u_if.address), 32'h1);
        run_cycles(40);
        check_val("to_sticky", 32'(u_if.timeout_err), 32'h1);
        spi_en = 1'b1;
        do_reset();
        check_val("to_cleared_by_reset", 32'(u_if.timeout_err), 32'h0);

        // Asynchronous reset in WAIT with ch1/ch3 pending
        put_ch(0, 12'h0F0);
        cycle();
        u_if.req = '0;
        cycle();
        cycle();
        put_ch(1, 12'h010); put_ch(3, 12'h030);
        cycle();
        u_if.req = '0;
        cycle();
        check_val("mid_pending", 32'(u_if.pending), 32'hA);
        check_val("mid_busy", 32'(u_if.busy), 32'h1);
        #3;
        rst          = 1'b1;
        u_if.dacdone = 1'b0;
        spi_cnt      = 0;
        model_reset();
        #1;
        check_val("mid_async_clear", dut_vec(), 32'h0);
        cycle();
        cycle();
        rst = 1'b0;
        g_log.delete();
        run_cycles(30);
        check_val("mid_no_trig_after", 32'(g_log.size()), 32'd0);
        put_ch(2, 12'h7E7);
        cycle();
        u_if.req = '0;
        cycle();
        check_val("mid_new_req_trig", 32'(u_if.dactrig), 32'h1);

        // Randomized traffic with stray dacdone pulses and latencies past the watchdog
        do_reset();
        noise_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            spi_lat      = $urandom_range(1, 20);
            u_if.wr_data = {16'($urandom), 32'($urandom)};
            u_if.req     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            cycle();
        end
        u_if.req = '0;
        noise_en = 1'b0;
        run_cycles(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
